// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 constants, controller state type and word helpers
package sm3_pkg;

  localparam int           BLK_BITS = 512;
  localparam logic [7:0]   PAD_BYTE = 8'h80;
  localparam logic [255:0] IV0 =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN} state_e;

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
  endfunction

endpackage

// File: rtl/sm3_CF.sv
// rtl/sm3_CF.sv - SM3 compression function, one round per clock, 64 rounds per block
module sm3_CF (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] iv,
  input  logic [511:0] block,
  output logic [255:0] hash,
  output logic         end_o    // "end" is a reserved word
);
  import sm3_pkg::*;

  logic              start_prev_q, start_prev_d;
  logic              run_q, run_d;
  logic [5:0]        rnd_q, rnd_d;
  logic [255:0]      v_q, v_d;
  logic [255:0]      st_q, st_d;
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      hash_q, hash_d;
  logic              end_q, end_d;
  logic [255:0]      st_next;
  logic [31:0]       w_new;

  // One compression round on A..H; w_q[0] holds W_j, the window runs 16 words ahead
  always_comb begin
    logic [31:0] a, b, c, d, e, f, g, h, tj, a12, ss1, ss2, ff, gg, tt1, tt2;
    {a, b, c, d, e, f, g, h} = st_q;
    tj  = (rnd_q < 6'd16) ? T_LO : T_HI;
    a12 = rol32(a, 5'd12);
    ss1 = rol32(a12 + e + rol32(tj, rnd_q[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    if (rnd_q < 6'd16) begin
      ff = a ^ b ^ c;
      gg = e ^ f ^ g;
    end else begin
      ff = (a & b) | (a & c) | (b & c);
      gg = (e & f) | (~e & g);
    end
    tt1     = ff + d + ss2 + (w_q[0] ^ w_q[4]);
    tt2     = gg + h + ss1 + w_q[0];
    st_next = {tt1, a, rol32(b, 5'd9), c, p0(tt2), e, rol32(f, 5'd19), g};
    w_new   = p1(w_q[0] ^ w_q[7] ^ rol32(w_q[13], 5'd15)) ^ rol32(w_q[3], 5'd7) ^ w_q[10];
  end

  // Start on a rising start edge so a start still high during the end cycle cannot relaunch
  always_comb begin
    start_prev_d = start;
    run_d        = run_q;
    rnd_d        = rnd_q;
    v_d          = v_q;
    st_d         = st_q;
    w_d          = w_q;
    hash_d       = hash_q;
    end_d        = 1'b0;
    if (!run_q) begin
      if (start && !start_prev_q) begin
        run_d = 1'b1;
        rnd_d = '0;
        v_d   = iv;
        st_d  = iv;
        for (int i = 0; i < 16; i++) w_d[i] = block[511-32*i -: 32];
      end
    end else begin
      st_d  = st_next;
      rnd_d = rnd_q + 6'd1;
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = w_new;
      if (rnd_q == 6'd63) begin
        run_d  = 1'b0;
        end_d  = 1'b1;
        hash_d = st_next ^ v_q;
      end
    end
  end

  // State registers; reset discards any round in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      run_q        <= 1'b0;
      rnd_q        <= '0;
      v_q          <= '0;
      st_q         <= '0;
      w_q          <= '0;
      hash_q       <= '0;
      end_q        <= 1'b0;
    end else begin
      start_prev_q <= start_prev_d;
      run_q        <= run_d;
      rnd_q        <= rnd_d;
      v_q          <= v_d;
      st_q         <= st_d;
      w_q          <= w_d;
      hash_q       <= hash_d;
      end_q        <= end_d;
    end
  end

  assign hash  = hash_q;
  assign end_o = end_q;

endmodule

// File: rtl/sm3_pad_hash.sv
// rtl/sm3_pad_hash.sv - fixed-length SM3 hasher: pads the message and chains NBLK CF ops; SM3_IV_LOAD_EN adds iv_sel/iv_in
module sm3_pad_hash #(
  parameter int MSG_BITS = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_BITS-1:0] msg,
`ifdef SM3_IV_LOAD_EN
  input  logic                iv_sel,
  input  logic [255:0]        iv_in,
`endif
  output logic                busy,
  output logic                done,
  output logic [255:0]        hash_value
);
  import sm3_pkg::*;

  localparam int NBLK     = (MSG_BITS + 65 + BLK_BITS - 1) / BLK_BITS;
  localparam int PAD_BITS = NBLK * BLK_BITS;
  localparam int BW       = $clog2(NBLK + 1);

  state_e                 state_q, state_d;
  logic [BW-1:0]          blk_q, blk_d;
  logic [255:0]           cv_q, cv_d;
  logic [MSG_BITS-1:0]    msg_q, msg_d;
  logic [255:0]           hash_q, hash_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PAD_BITS-1:0]    pad_w;
  logic [BLK_BITS-1:0]    cf_block;
  logic [255:0]           cf_hash;
  logic [255:0]           iv_start;
  logic                   cf_start;
  logic                   cf_end;

`ifdef SM3_IV_LOAD_EN
  assign iv_start = iv_sel ? iv_in : IV0;
`else
  assign iv_start = IV0;
`endif

  // Padded image: message, 0x80, zero fill, 64-bit bit length in the last word
  always_comb begin
    pad_w = '0;
    pad_w[PAD_BITS-1 -: MSG_BITS]       = msg_q;
    pad_w[PAD_BITS-MSG_BITS-1 -: 8]     = PAD_BYTE;
    pad_w[63:0]                         = 64'(MSG_BITS);
  end

  // Block select by index; block 0 is the most significant 512 bits
  always_comb begin
    cf_block = '0;
    for (int i = 0; i < NBLK; i++)
      if (blk_q == BW'(i)) cf_block = pad_w[PAD_BITS-1-i*BLK_BITS -: BLK_BITS];
  end

  assign cf_start = (state_q == ISSUE) || (state_q == WAIT);

  // Job sequencing: issue a block, wait for the CF, one idle gap, repeat, then publish
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cv_d    = cv_q;
    msg_d   = msg_q;
    hash_d  = hash_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_d   = msg;
          cv_d    = iv_start;
          blk_d   = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cf_end) begin
          cv_d    = cf_hash;
          blk_d   = blk_q + BW'(1);
          state_d = (blk_q == BW'(NBLK - 1)) ? FIN : GAP;
        end
      end
      GAP: state_d = ISSUE;
      FIN: begin
        hash_d  = cv_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers, all cleared or set to IV0 by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      blk_q   <= '0;
      cv_q    <= IV0;
      msg_q   <= '0;
      hash_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cv_q    <= cv_d;
      msg_q   <= msg_d;
      hash_q  <= hash_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sm3_CF u_cf (
    .clk     (clk),
    .reset_n (~reset),
    .start   (cf_start),
    .iv      (cv_q),
    .block   (cf_block),
    .hash    (cf_hash),
    .end_o   (cf_end)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign hash_value = hash_q;

endmodule

// File: tb/tb_sm3_pad_hash.sv
// tb/tb_sm3_pad_hash.sv - checks sm3_pad_hash at several message lengths against an SM3 reference model
module tb_sm3_pad_hash;

  localparam int NI = 5;
  localparam logic [255:0] IV_REF =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] ABC_GOLD =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD_GOLD =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic            clk = 1'b0;
  logic            reset;
  logic [NI-1:0]   start_v, busy_v, done_v, cfs_v;
  logic [255:0]    hash_v [NI];
  logic [4095:0]   msg_all;
`ifdef SM3_IV_LOAD_EN
  logic            iv_sel;
  logic [255:0]    iv_in;
`endif
  int              n_pass = 0;
  int              n_total = 0;

  always #5 clk = ~clk;

  function automatic int bits_of(input int g);
    case (g)
      0: return 24;
      1: return 440;
      2: return 448;
      3: return 512;
      default: return 4096;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int B = bits_of(g);
    sm3_pad_hash #(.MSG_BITS(B)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .msg        (msg_all[B-1:0]),
`ifdef SM3_IV_LOAD_EN
      .iv_sel     (iv_sel),
      .iv_in      (iv_in),
`endif
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .hash_value (hash_v[g])
    );
    assign cfs_v[g] = u_dut.cf_start;
  end

  // ---------------- reference model (byte queue + full W arrays) ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rp0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] rp1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  function automatic logic [255:0] ref_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] r [8];
    logic [31:0] ss1, ss2, tt1, tt2, ff, gg, t;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = rp1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    for (int k = 0; k < 8; k++) r[k] = v[255-32*k -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rol(rol(r[0], 12) + r[4] + rol(t, j % 32), 7);
      ss2 = ss1 ^ rol(r[0], 12);
      ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + r[7] + ss1 + w[j];
      r[3] = r[2]; r[2] = rol(r[1], 9); r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rol(r[5], 19); r[5] = r[4]; r[4] = rp0(tt2);
    end
    return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
  endfunction

  function automatic logic [255:0] ref_hash(input logic [4095:0] m, input int bits,
                                            input logic [255:0] iv, output int nb);
    logic [7:0]   q [$];
    logic [511:0] blkv;
    logic [255:0] v;
    logic [63:0]  len;
    len = 64'(bits);
    for (int i = 0; i < bits / 8; i++) q.push_back(m[bits-1-8*i -: 8]);
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 7; k >= 0; k--) q.push_back(len[8*k +: 8]);
    nb = q.size() / 64;
    v  = iv;
    for (int bi = 0; bi < nb; bi++) begin
      for (int k = 0; k < 64; k++) blkv[511-8*k -: 8] = q[bi*64+k];
      v = ref_cf(v, blkv);
    end
    return v;
  endfunction

  function automatic logic [4095:0] rand_msg();
    logic [4095:0] m;
    for (int k = 0; k < 128; k++) m[32*k +: 32] = $urandom;
    return m;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; start is applied immediately, returns at a negedge
  task automatic run_job(input int i, input logic [4095:0] m, input bit poke, input int tail,
                         output logic [255:0] h, output int nrise, output int ndone);
    bit prev, seen;
    h = '0; nrise = 0; ndone = 0; seen = 1'b0; prev = 1'b0;
    msg_all    = m;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    check("busy_after_start", busy_v[i], 1);
    for (int c = 0; c < 1500 && !seen; c++) begin
      if (cfs_v[i] && !prev) nrise++;
      prev = cfs_v[i];
      if (poke) begin
        msg_all    = ~m;
        start_v[i] = (c < 6);
      end
      @(negedge clk);
      if (done_v[i]) begin
        ndone++;
        h    = hash_v[i];
        seen = 1'b1;
        check("busy_low_at_done", busy_v[i], 0);
      end
    end
    start_v[i] = 1'b0;
    check("done_seen_in_budget", seen, 1);
    for (int c = 0; c < tail; c++) begin
      @(negedge clk);
      if (done_v[i]) ndone++;
      if (cfs_v[i] && !prev) nrise++;
      prev = cfs_v[i];
    end
  endtask

  typedef struct {
    int            inst;
    logic [4095:0] msg;
    int            exp_blocks;
    bit            has_golden;
    logic [255:0]  golden;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary, required finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t          vecs [7];
    logic [255:0]  h, exp_h, x_iv;
    logic [4095:0] m, m2;
    int            nrise, ndone, nb, nr;
    bit            prev;

    reset   = 1'b1;
    start_v = '0;
    msg_all = '0;
`ifdef SM3_IV_LOAD_EN
    iv_sel  = 1'b0;
    iv_in   = '0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_busy", busy_v[i], 0);
      check("reset_done", done_v[i], 0);
      check("reset_cf_start", cfs_v[i], 0);
      check("reset_hash", hash_v[i], 0);
    end
    reset = 1'b0;

    vecs[0].inst = 0; vecs[0].msg = '0; vecs[0].msg[23:0] = 24'h616263;
    vecs[0].exp_blocks = 1; vecs[0].has_golden = 1'b1; vecs[0].golden = ABC_GOLD;
    vecs[1].inst = 0; vecs[1].msg = rand_msg(); vecs[1].exp_blocks = 1;
    vecs[1].has_golden = 1'b0; vecs[1].golden = '0;
    vecs[2].inst = 3; vecs[2].msg = '0; vecs[2].msg[511:0] = {16{32'h61626364}};
    vecs[2].exp_blocks = 2; vecs[2].has_golden = 1'b1; vecs[2].golden = ABCD_GOLD;
    vecs[3].inst = 1; vecs[3].msg = rand_msg(); vecs[3].exp_blocks = 1;
    vecs[3].has_golden = 1'b0; vecs[3].golden = '0;
    vecs[4].inst = 2; vecs[4].msg = rand_msg(); vecs[4].exp_blocks = 2;
    vecs[4].has_golden = 1'b0; vecs[4].golden = '0;
    vecs[5].inst = 4; vecs[5].msg = rand_msg(); vecs[5].exp_blocks = 9;
    vecs[5].has_golden = 1'b0; vecs[5].golden = '0;
    vecs[6].inst = 3; vecs[6].msg = rand_msg(); vecs[6].exp_blocks = 2;
    vecs[6].has_golden = 1'b0; vecs[6].golden = '0;

    // First job starts on the first clock after reset release; jobs follow one cycle after done
    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].inst, vecs[v].msg, 1'b0, 1, h, nrise, ndone);
      exp_h = ref_hash(vecs[v].msg, bits_of(vecs[v].inst), IV_REF, nb);
      check($sformatf("v%0d_model_blocks", v), nb, vecs[v].exp_blocks);
      check($sformatf("v%0d_cf_start_rises", v), nrise, vecs[v].exp_blocks);
      check($sformatf("v%0d_done_pulses", v), ndone, 1);
      check($sformatf("v%0d_digest", v), h, exp_h);
      if (vecs[v].has_golden) begin
        check($sformatf("v%0d_model_golden", v), exp_h, vecs[v].golden);
        check($sformatf("v%0d_digest_golden", v), h, vecs[v].golden);
      end
    end

    // Start held while busy and msg changed after acceptance
    m = rand_msg();
    run_job(3, m, 1'b1, 5, h, nrise, ndone);
    exp_h = ref_hash(m, 512, IV_REF, nb);
    check("busy_start_digest", h, exp_h);
    check("busy_start_done_pulses", ndone, 1);
    check("busy_start_rises", nrise, 2);

    // Reset in the middle of block 4 of a 4096-bit job
    m = rand_msg();
    msg_all    = m;
    start_v[4] = 1'b1;
    @(negedge clk);
    start_v[4] = 1'b0;
    nr = 0; prev = 1'b0;
    for (int c = 0; c < 2000 && nr < 5; c++) begin
      @(negedge clk);
      if (cfs_v[4] && !prev) nr++;
      prev = cfs_v[4];
    end
    check("midjob_reached_blk4", nr, 5);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midjob_reset_busy", busy_v[4], 0);
    check("midjob_reset_cf_start", cfs_v[4], 0);
    check("midjob_reset_done", done_v[4], 0);
    check("midjob_reset_hash", hash_v[4], 0);
    reset = 1'b0;
    m2 = rand_msg();
    run_job(4, m2, 1'b0, 3, h, nrise, ndone);
    exp_h = ref_hash(m2, 4096, IV_REF, nb);
    check("after_reset_digest", h, exp_h);
    check("after_reset_rises", nrise, 9);
    check("after_reset_done_pulses", ndone, 1);

`ifdef SM3_IV_LOAD_EN
    // Chain: block-0 output of a longer message loaded as IV for its second block
    m = rand_msg();
    x_iv   = ref_cf(IV_REF, m[1023:512]);
    m2     = '0;
    m2[511:0] = m[511:0];
    iv_sel = 1'b1;
    iv_in  = x_iv;
    run_job(3, m2, 1'b0, 1, h, nrise, ndone);
    iv_sel = 1'b0;
    exp_h  = ref_hash(m2, 512, x_iv, nb);
    check("iv_load_digest", h, exp_h);
    check("iv_load_rises", nrise, 2);
`else
    x_iv = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sm3_pad_hash.md
SM3_PAD_HASH -- requirements
Module: sm3_pad_hash

Interface
REQ-001 SHALL have parameter MSG_BITS, default 4096, meaning fixed message length in bits; legal range 8..8192, multiple of 8.
REQ-002 SHALL have localparam NBLK = ceil((MSG_BITS+65)/512), the padded block count (9 at default).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request pulse sampled only in IDLE.
REQ-006 SHALL have port msg, input, MSG_BITS, the message with its first byte in the MSB; sampled only on the accepted start cycle.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when hash_value is valid.
REQ-009 SHALL have port hash_value, output, 256, the digest; held stable until the next accepted start.

Function
REQ-010 SHALL capture msg into an internal register on an accepted start, so that msg may change afterwards.
REQ-011 SHALL form the padded message as {msg, 8'h80, Z zero bits, 64-bit MSG_BITS}, with Z chosen so the total is NBLK*512; block 0 is the most-significant 512 bits.
REQ-012 SHALL select the current block by block-index multiplexing from the captured register; no RAM is used.
REQ-013 SHALL use states IDLE, ISSUE, WAIT, GAP and FIN.
REQ-014 SHALL transition IDLE->ISSUE on start, setting the chaining value to IV0 = 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e and blk=0.
REQ-015 SHALL, in ISSUE, assert cf_start with the block and chaining value stable, then go to WAIT.
REQ-016 SHALL, in WAIT, hold cf_start high until cf_end; on cf_end it SHALL drop cf_start, load the chaining value from the CF output and increment blk.
REQ-017 SHALL, after the cf_end handling in WAIT, go to FIN if blk was NBLK-1, otherwise to GAP.
REQ-018 SHALL hold cf_start low in GAP for exactly one cycle, then return to ISSUE; cf_start SHALL therefore be low for at least one cycle between blocks.
REQ-019 SHALL, in FIN, register hash_value, pulse done for one cycle, drop busy and return to IDLE.
REQ-020 SHALL ignore start while busy; no queueing and no restart.
REQ-021 SHALL accept a start in the cycle after done.
REQ-022 SHALL have the block counter width $clog2(NBLK+1); it never wraps inside a job.
REQ-023 SHALL issue exactly NBLK CF operations per job.

Reset
REQ-024 SHALL force, on reset asserted at any time including mid-job: state=IDLE, busy=0, done=0, cf_start=0, blk=0, chaining value=IV0, hash_value=0.
REQ-025 SHALL discard any in-flight CF result after reset.
REQ-026 SHALL accept the first start on the first clock after reset deassertion.

Configuration
REQ-027 SHALL, when SM3_IV_LOAD_EN is defined, add input iv_sel (1) and input iv_in (256); if iv_sel=1 on the accepted start, the chaining value is loaded from iv_in instead of IV0, and the length field is unchanged.
REQ-028 SHALL, when SM3_IV_LOAD_EN is undefined, omit iv_sel and iv_in and always use IV0.

Structure
REQ-029 SHALL take IV0, the 8'h80 pad byte and the block width 512 from shared package sm3_pkg.
REQ-030 SHALL instantiate exactly one sub-module, the existing sm3_CF compression function, with ports (clk, reset_n, start, iv, block, hash, end).
REQ-031 SHALL drive the reset_n port of sm3_CF with ~reset.

Verification
REQ-032 SHALL verify MSG_BITS=24, msg=24'h616263, start -> one CF op, done, hash_value = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
REQ-033 SHALL verify MSG_BITS=512, msg = "abcd" repeated 16 times -> two CF ops, hash_value = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
REQ-034 SHALL verify the padding boundary: MSG_BITS=440 -> exactly 1 cf_start rise; MSG_BITS=448 -> exactly 2; default 4096 -> exactly 9; each digest matches the golden model.
REQ-035 SHALL verify that a start pulsed while busy and msg changed after acceptance -> digest equal to the original message's digest, and a single done pulse.
REQ-036 SHALL verify reset asserted during block 4 of a 4096-bit job -> busy=0, cf_start=0 next cycle; a new job then gives the correct digest.
REQ-037 SHALL verify, with SM3_IV_LOAD_EN defined and iv_sel=1, that iv_in set to the block-0 output of a 1024-bit job, fed the remaining block of that job, gives the expected chained digest.
